dot_product_row_feeder: RTL and testbench

- Upstream stage of the 128-lane dot-product engine.
- Fetches matrix-row and vector packages (NO_OF_UNITS elements each) from two package-wide memories and presents them on first/second row buses.
- Pulses the engine's read-now strobe once per package and holds data stable while the engine consumes both halves.
- Waits for the engine's finish, captures the scalar result, and reports done to the controller.

---
 rtl/dot_product_row_feeder.sv | 145 ++++++++++++++
 tb/tb_dot_product_row_feeder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_row_feeder.sv
// Row feeder for the dot-product engine: fetches matrix/vector packages, strobes the engine once per package, captures the result.
// Optional cycle counter output enabled by defining DOT_PRODUCT_ROW_FEEDER_PERF_EN.
module dot_product_row_feeder #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int NO_OF_UNITS   = 128,
  parameter int ADDR_W        = 10,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [31:0]                          total,
  input  logic [ADDR_W-1:0]                    mat_base_addr,
  input  logic [ADDR_W-1:0]                    vec_base_addr,
  output logic                                 mem_rd_en,
  output logic [ADDR_W-1:0]                    mat_addr,
  output logic [ADDR_W-1:0]                    vec_addr,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mat_rd_data,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] vec_rd_data,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] first_row_output,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] second_row_output,
  output logic                                 outsider_read_now,
  output logic [31:0]                          dp_total,
  output logic                                 dp_clear,
  input  logic                                 dp_finish,
  input  logic [ELEMENT_WIDTH-1:0]             dp_result,
  output logic [ELEMENT_WIDTH-1:0]             result,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
`ifdef DOT_PRODUCT_ROW_FEEDER_PERF_EN
  output logic [31:0]                          cycle_count,
`endif
  output logic [2:0]                           state_dbg
);

  localparam int LOG2_U = $clog2(NO_OF_UNITS);
  localparam int HC_W   = $clog2(HOLD_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LOAD, S_PULSE, S_HOLD, S_WAIT_FIN, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         npkg_q, pkg_q;
  logic [ADDR_W-1:0]   mat_addr_q, vec_addr_q;
  logic [HC_W-1:0]     hold_cnt_q;
  logic                fin_prev_q;
  logic                err_q;
  logic                total_ok, start_ok, hold_last, fin_edge;

  assign total_ok  = (total != 32'd0) && (total[LOG2_U-1:0] == '0);
  assign start_ok  = start && total_ok;
  assign hold_last = (hold_cnt_q == HC_W'(HOLD_CYCLES - 1));
  assign fin_edge  = dp_finish && !fin_prev_q;

  // Package strobe: outsider_read_now is high for one cycle when both row
  // buses carry a fresh package; the buses then stay unchanged until the
  // next package is loaded, so the engine needs no ready/ack back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_ok) state_d = S_READ;
      S_READ:     state_d = S_LOAD;
      S_LOAD:     state_d = S_PULSE;
      S_PULSE:    state_d = S_HOLD;
      S_HOLD:     if (hold_last) state_d = (pkg_q < npkg_q) ? S_READ : S_WAIT_FIN;
      S_WAIT_FIN: if (fin_edge) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en         = (state_q == S_READ);
    outsider_read_now = (state_q == S_PULSE);
    busy              = (state_q != S_IDLE);
    dp_clear          = (state_q == S_IDLE);
    done              = (state_q == S_DONE);
  end

  assign mat_addr  = mat_addr_q;
  assign vec_addr  = vec_addr_q;
  assign err       = err_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      npkg_q            <= '0;
      pkg_q             <= '0;
      mat_addr_q        <= '0;
      vec_addr_q        <= '0;
      hold_cnt_q        <= '0;
      fin_prev_q        <= 1'b0;
      err_q             <= 1'b0;
      dp_total          <= '0;
      result            <= '0;
      first_row_output  <= '0;
      second_row_output <= '0;
    end else begin
      err_q      <= (state_q == S_IDLE) && start && !total_ok;
      fin_prev_q <= dp_finish;
      case (state_q)
        S_IDLE: begin
          fin_prev_q <= 1'b0;
          if (start_ok) begin
            dp_total   <= total;
            npkg_q     <= total >> LOG2_U;
            pkg_q      <= '0;
            mat_addr_q <= mat_base_addr;
            vec_addr_q <= vec_base_addr;
          end
        end
        S_LOAD: begin
          first_row_output  <= mat_rd_data;
          second_row_output <= vec_rd_data;
        end
        S_PULSE: begin
          pkg_q      <= pkg_q + 32'd1;
          mat_addr_q <= mat_addr_q + 1'b1;
          vec_addr_q <= vec_addr_q + 1'b1;
          hold_cnt_q <= '0;
        end
        S_HOLD:     hold_cnt_q <= hold_cnt_q + 1'b1;
        S_WAIT_FIN: if (fin_edge) result <= dp_result;
        default: ;
      endcase
    end
  end

`ifdef DOT_PRODUCT_ROW_FEEDER_PERF_EN
  // Counts every busy cycle including DONE, so it holds the job length once idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             cycle_count <= '0;
    else if (state_q == S_IDLE && start_ok) cycle_count <= '0;
    else if (busy && cycle_count != '1)     cycle_count <= cycle_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_dot_product_row_feeder.sv
// Self-checking bench for dot_product_row_feeder: table of jobs plus hand-written reset and finish-edge sequences.
module tb_dot_product_row_feeder;

  localparam int EW = 32;
  localparam int NU = 128;
  localparam int AW = 10;
  localparam int DW = EW * NU;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   total;
  logic [AW-1:0] mat_base_addr, vec_base_addr;
  logic          mem_rd_en;
  logic [AW-1:0] mat_addr, vec_addr;
  logic [DW-1:0] mat_rd_data, vec_rd_data;
  logic [DW-1:0] first_row_output, second_row_output;
  logic          outsider_read_now;
  logic [31:0]   dp_total;
  logic          dp_clear;
  logic          dp_finish;
  logic [EW-1:0] dp_result;
  logic [EW-1:0] result;
  logic          busy, done, err;
  logic [2:0]    state_dbg;
`ifdef DOT_PRODUCT_ROW_FEEDER_PERF_EN
  logic [31:0]   cycle_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW-1:0] exp_mat_q[$];
  logic [AW-1:0] exp_vec_q[$];

  dot_product_row_feeder dut (
    .clk(clk), .reset(reset), .start(start), .total(total),
    .mat_base_addr(mat_base_addr), .vec_base_addr(vec_base_addr),
    .mem_rd_en(mem_rd_en), .mat_addr(mat_addr), .vec_addr(vec_addr),
    .mat_rd_data(mat_rd_data), .vec_rd_data(vec_rd_data),
    .first_row_output(first_row_output), .second_row_output(second_row_output),
    .outsider_read_now(outsider_read_now), .dp_total(dp_total), .dp_clear(dp_clear),
    .dp_finish(dp_finish), .dp_result(dp_result), .result(result),
    .busy(busy), .done(done), .err(err),
`ifdef DOT_PRODUCT_ROW_FEEDER_PERF_EN
    .cycle_count(cycle_count),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mk_pkg(input logic [7:0] tag, input logic [AW-1:0] a);
    logic [DW-1:0] p;
    logic [11:0]   idx;
    for (int i = 0; i < NU; i++) begin
      idx = 12'(i);
      p[i*EW +: EW] = {tag, 2'b00, a, idx};
    end
    return p;
  endfunction

  // memory model: one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mat_rd_data <= mk_pkg(8'hA5, mat_addr);
      vec_rd_data <= mk_pkg(8'h5A, vec_addr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_row(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got word0 %0h expected word0 %0h", name, act[EW-1:0], exp[EW-1:0]);
    end
  endtask

  typedef struct {
    logic [31:0]   total;
    logic [AW-1:0] mb;
    logic [AW-1:0] vb;
    bit            exp_err;
    int            pkgs;
    logic [31:0]   fin;
    bit            fin_held;
  } vec_t;

  // driver: run one job end to end, checking addresses, strobes, data and result
  task automatic run_job(input vec_t r);
    int            cyc, strobes, last;
    int            busy_cycles;
    bit            stable, got_done, fin_sent, rd_seen;
    logic [AW-1:0] cur_m, cur_v;
    logic [DW-1:0] snap_m, snap_v;
    cyc = 1; strobes = 0; last = 0; busy_cycles = 0;
    stable = 1; got_done = 0; fin_sent = 0; rd_seen = 0;
    cur_m = '0; cur_v = '0; snap_m = '0; snap_v = '0;
    exp_mat_q.delete();
    exp_vec_q.delete();

    @(negedge clk);
    start = 1'b1; total = r.total; mat_base_addr = r.mb; vec_base_addr = r.vb;
    @(negedge clk);
    start = 1'b0;

    if (r.exp_err) begin
      check("err_pulse", {31'd0, err}, 32'd1);
      check("err_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 3; i++) begin
        rd_seen |= mem_rd_en | busy;
        @(negedge clk);
      end
      check("err_no_read", {31'd0, rd_seen}, 32'd0);
      check("err_one_cycle", {31'd0, err}, 32'd0);
      return;
    end

    for (int k = 0; k < r.pkgs; k++) begin
      exp_mat_q.push_back(r.mb + AW'(k));
      exp_vec_q.push_back(r.vb + AW'(k));
    end
    check("clear_low_in_read", {31'd0, dp_clear}, 32'd0);
    check("dp_total", dp_total, r.total);

    while (!got_done && cyc < 400) begin
      if (busy) busy_cycles++;
      if (mem_rd_en) begin
        if (exp_mat_q.size() == 0) begin
          check("extra_read", 32'd1, 32'd0);
        end else begin
          cur_m = exp_mat_q.pop_front();
          cur_v = exp_vec_q.pop_front();
          check("mat_addr", 32'(mat_addr), 32'(cur_m));
          check("vec_addr", 32'(vec_addr), 32'(cur_v));
        end
      end
      if (outsider_read_now) begin
        strobes++;
        if (strobes == 1) check("first_strobe_latency", cyc, 3);
        else              check("strobe_interval", cyc - last, 5);
        last = cyc;
        check_row("first_row", first_row_output, mk_pkg(8'hA5, cur_m));
        check_row("second_row", second_row_output, mk_pkg(8'h5A, cur_v));
        snap_m = first_row_output;
        snap_v = second_row_output;
      end else if (strobes > 0) begin
        if (first_row_output !== snap_m || second_row_output !== snap_v) stable = 0;
      end
      if (strobes == r.pkgs && !fin_sent) begin
        if (!r.fin_held) begin
          if (cyc == last + 4) begin
            dp_finish = 1'b1; dp_result = r.fin; fin_sent = 1;
          end
        end else begin
          if (cyc == last + 1) begin
            dp_finish = 1'b1; dp_result = 32'hDEADBEEF;
          end else if (cyc == last + 8) begin
            check("held_no_done", {31'd0, done}, 32'd0);
            check("held_still_busy", {31'd0, busy}, 32'd1);
            dp_finish = 1'b0;
          end else if (cyc == last + 9) begin
            dp_finish = 1'b1; dp_result = r.fin; fin_sent = 1;
          end
        end
      end
      if (done) begin
        got_done = 1;
        check("result", result, r.fin);
      end
      @(negedge clk);
      cyc++;
    end

    if (!got_done) check("done_timeout", 32'd0, 32'd1);
    check("strobe_count", strobes, r.pkgs);
    check("data_stable", {31'd0, stable}, 32'd1);
    check("reads_all_issued", exp_mat_q.size(), 0);
    check("busy_low_after", {31'd0, busy}, 32'd0);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("clear_back_high", {31'd0, dp_clear}, 32'd1);
    check("result_held", result, r.fin);
`ifdef DOT_PRODUCT_ROW_FEEDER_PERF_EN
    check("cycle_count", cycle_count, busy_cycles);
`endif
    dp_finish = 1'b0;
  endtask

  vec_t tbl[6];
  vec_t job128;

  initial begin
    tbl[0] = '{total: 32'd128, mb: 10'd0,    vb: 10'd0,  exp_err: 0, pkgs: 1, fin: 32'h3F800000, fin_held: 0};
    tbl[1] = '{total: 32'd512, mb: 10'd10,   vb: 10'd20, exp_err: 0, pkgs: 4, fin: 32'h40490FDB, fin_held: 0};
    tbl[2] = '{total: 32'd0,   mb: 10'd5,    vb: 10'd5,  exp_err: 1, pkgs: 0, fin: 32'h0,        fin_held: 0};
    tbl[3] = '{total: 32'd100, mb: 10'd5,    vb: 10'd5,  exp_err: 1, pkgs: 0, fin: 32'h0,        fin_held: 0};
    tbl[4] = '{total: 32'd256, mb: 10'd1023, vb: 10'd7,  exp_err: 0, pkgs: 2, fin: 32'hC0000000, fin_held: 0};
    tbl[5] = '{total: 32'd128, mb: 10'd3,    vb: 10'd4,  exp_err: 0, pkgs: 1, fin: 32'h12345678, fin_held: 1};
    job128 = '{total: 32'd128, mb: 10'd50,   vb: 10'd60, exp_err: 0, pkgs: 1, fin: 32'h41200000, fin_held: 0};

    reset = 1'b0; start = 1'b0; total = '0; mat_base_addr = '0; vec_base_addr = '0;
    dp_finish = 1'b0; dp_result = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_clear", {31'd0, dp_clear}, 32'd1);
    check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_strobe", {31'd0, outsider_read_now}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int t = 0; t < 6; t++) run_job(tbl[t]);

    // mid-job reset during the second HOLD of a 512 job
    begin
      int strobes_seen;
      strobes_seen = 0;
      @(negedge clk);
      start = 1'b1; total = 32'd512; mat_base_addr = 10'd100; vec_base_addr = 10'd200;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40 && strobes_seen < 2; i++) begin
        if (outsider_read_now) strobes_seen++;
        if (strobes_seen < 2) @(negedge clk);
      end
      check("midrst_reached", strobes_seen, 2);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_strobe_rd", {30'd0, outsider_read_now, mem_rd_en}, 32'd0);
      check_row("midrst_first_row", first_row_output, '0);
      check_row("midrst_second_row", second_row_output, '0);
      check("midrst_dp_total", dp_total, 32'd0);
      check("midrst_addr", {22'd0, mat_addr}, 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_clear", {31'd0, dp_clear}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
    end
    run_job(job128);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
